toggle_activity_meter: RTL
==========================

// Module: toggle_activity_meter
// PURPOSE
//  Downstream consumer of the bcounter8 count bus: measures switching activity of an 8-bit bus
//  (bits toggled between consecutive valid samples) over fixed windows of WIN samples.
//  Reports total toggles and the peak per-sample toggle count through a valid/ready result port.
//  Feeds the power-estimation flow with per-window activity figures for the counter output q.
// PARAMETERS
//  WIDTH  8   monitored bus width
//  WIN    16  window length, in counted (post-prime) valid samples; WIN >= 1
//  ACCW   $clog2(WIDTH*WIN+1) (=8)  width of out_total
//  PKW    $clog2(WIDTH+1) (=4)      width of out_peak
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-low reset
//  in_valid   in   1      in_data is a sample this cycle
//  in_data    in   WIDTH  monitored bus (bcounter8 q)
//  out_valid  out  1      result registers hold an unread window result
//  out_ready  in   1      consumer accepts result when out_valid&&out_ready
//  out_total  out  ACCW   sum of per-sample toggle counts over the window
//  out_peak   out  PKW    max per-sample toggle count in the window
//  overrun    out  1      sticky: an unread result was overwritten
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=PRIME, prev=0, acc=0, peak=0, cnt=0; out_valid=0,
//    out_total=0, out_peak=0, overrun=0. Reset mid-window discards all partial data.
//  - in_valid=0: no state change in the datapath (handshake logic still runs).
//  - PRIME: first valid sample loads prev only; no toggles counted, cnt unchanged; -> ACCUM.
//  - ACCUM, valid sample: hd = popcount(in_data ^ prev); prev <= in_data.
//    cnt < WIN-1: acc += hd, peak = max(peak,hd), cnt++.
//    cnt == WIN-1 (window end): out_total <= acc+hd, out_peak <= max(peak,hd), out_valid <= 1,
//    acc<=0, peak<=0, cnt<=0; stay in ACCUM (windows back-to-back, no gap, prev retained).
//  - Latency: result visible the cycle after the posedge capturing the last sample.
//  - Widths: acc is ACCW bits, never overflows (max WIDTH*WIN); hd is PKW bits.
//  - Handshake: out_valid&&out_ready at posedge clears out_valid; result regs stable while
//    out_valid=1 and no new window ends.
//  - Window end with out_valid=1 and out_ready=0: overwrite results, out_valid stays 1,
//    overrun <= 1 (cleared only by reset).
//  - Window end coincident with out_valid&&out_ready: new result loaded, out_valid stays 1,
//    no overrun.
//  - out_ready while out_valid=0: ignored.
// STRUCTURE
//  - Shared package/header: state encoding (PRIME, ACCUM), ACCW/PKW width functions.
//  - Sub-module hamming_dist (combinational XOR+popcount, WIDTH in, PKW out); rest is one
//    FSM + accumulator + result/handshake register block.
// TESTING (WIDTH=8, WIN=16, drive from bcounter8 or equivalent stimulus)
//  1. Counter 0,1,...,32 (valid every cycle), out_ready=1 -> first result total=31, peak=5
//     (0x0F->0x10); second result total=32, peak=6 (0x1F->0x20); overrun=0.
//  2. Constant 0xA5 for 17 valid samples -> total=0, peak=0 one cycle after the 17th sample.
//  3. Alternating 0x00/0xFF, 17 samples -> total=128, peak=8 (full-scale acc, no overflow).
//  4. out_ready=0 across two window ends -> out_valid stays 1, overrun=1, second result held;
//     then out_ready=1 for one cycle -> out_valid=0, overrun remains 1.
//  5. in_valid toggled 50% random with counter stimulus -> results match the valid-only
//     sample stream; window end coincident with out_ready handshake -> out_valid stays 1,
//     no overrun.
//  6. reset low mid-window (after 7 samples) -> all outputs 0 next cycle; next valid sample
//     re-primes; first result then spans exactly 16 counted samples.

Source files
------------

// File: rtl/toggle_activity_meter_pkg.sv
// Shared definitions for the toggle activity meter: FSM state encoding and
// the width helpers used to size the accumulator and per-sample toggle count.
package toggle_activity_meter_pkg;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Accumulator must hold WIDTH*WIN without overflow.
    function automatic int acc_width(input int width, input int win);
        return $clog2(width * win + 1);
    endfunction

    function automatic int pk_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/toggle_activity_meter_hamming_dist.sv
// Combinational Hamming distance: number of bit positions that differ
// between two WIDTH-bit words.
module hamming_dist
    import toggle_activity_meter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PKW   = pk_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [PKW-1:0]   o_dist
);

    logic [WIDTH-1:0] w_diff;
    logic [PKW-1:0]   w_count;

    assign w_diff = i_a ^ i_b;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_count = w_count + PKW'(w_diff[i]);
        end
    end

    assign o_dist = w_count;

endmodule

// File: rtl/toggle_activity_meter.sv
// Measures bit toggles between consecutive valid samples of a bus over
// back-to-back windows of WIN counted samples; reports total and peak.
module toggle_activity_meter
    import toggle_activity_meter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WIN   = 16,
    parameter int ACCW  = acc_width(WIDTH, WIN),
    parameter int PKW   = pk_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACCW-1:0]  out_total,
    output logic [PKW-1:0]   out_peak,
    output logic             overrun,
    output state_t           o_dbg_state
);

    localparam int              CNTW     = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIN - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_prev;
    logic [ACCW-1:0]  r_acc;
    logic [PKW-1:0]   r_peak;
    logic [CNTW-1:0]  r_cnt;
    logic             r_out_valid;
    logic [ACCW-1:0]  r_out_total;
    logic [PKW-1:0]   r_out_peak;
    logic             r_overrun;

    logic [PKW-1:0]   w_hd;
    logic [ACCW-1:0]  w_acc_new;
    logic [PKW-1:0]   w_peak_new;
    logic             w_count_sample;
    logic             w_window_end;

    hamming_dist #(
        .WIDTH (WIDTH),
        .PKW   (PKW)
    ) u_hd (
        .i_a    (in_data),
        .i_b    (r_prev),
        .o_dist (w_hd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == PRIME && in_valid) begin
            w_state_next = ACCUM;
        end
    end

    assign w_count_sample = (r_state == ACCUM) && in_valid;
    assign w_window_end   = w_count_sample && (r_cnt == CNT_LAST);
    assign w_acc_new      = r_acc + ACCW'(w_hd);
    assign w_peak_new     = (w_hd > r_peak) ? w_hd : r_peak;

    // Result port: out_valid stays high until a cycle with out_valid && out_ready;
    // a window ending in that same cycle reloads the result and keeps out_valid high,
    // and one ending while the old result is still unaccepted sets the sticky overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev      <= '0;
            r_acc       <= '0;
            r_peak      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_total <= '0;
            r_out_peak  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (in_valid) begin
                r_prev <= in_data;
            end
            if (w_window_end) begin
                r_out_total <= w_acc_new;
                r_out_peak  <= w_peak_new;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end
                r_acc  <= '0;
                r_peak <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_count_sample) begin
                    r_acc  <= w_acc_new;
                    r_peak <= w_peak_new;
                    r_cnt  <= r_cnt + CNTW'(1);
                end
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_total   = r_out_total;
    assign out_peak    = r_out_peak;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule
